// File: rtl/bsg_async_fifo_read_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : bsg_async_fifo_read_ctrl_if
// Description : Read-domain bundle for the asynchronous FIFO read controller.
//               Carries the synchronized write pointer and pop handshake in,
//               and the status, address and read pointers out.
//   master : the read controller (drives status/pointers)
//   slave  : the consumer / pointer-sync environment
// Revision    : 1.0 - initial release
// ============================================================================
interface bsg_async_fifo_read_ctrl_if #(
    parameter int lg_size_p = 6
);
    logic [lg_size_p-1:0] r_w_ptr_gray_i;   // synchronized write gray pointer
    logic                 r_yumi_i;         // consumer takes head entry
    logic                 r_valid_o;        // FIFO non-empty
    logic [lg_size_p-2:0] r_addr_o;         // memory read address
    logic [lg_size_p-1:0] r_ptr_binary_r_o; // registered binary read pointer
    logic [lg_size_p-1:0] r_ptr_gray_r_o;   // registered gray read pointer
    logic [lg_size_p-1:0] r_count_o;        // occupancy
    logic                 r_underflow_o;    // sticky pop-while-empty
    logic                 r_overflow_o;     // sticky occupancy > depth

    modport master (
        input  r_w_ptr_gray_i, r_yumi_i,
        output r_valid_o, r_addr_o, r_ptr_binary_r_o, r_ptr_gray_r_o,
               r_count_o, r_underflow_o, r_overflow_o
    );

    modport slave (
        output r_w_ptr_gray_i, r_yumi_i,
        input  r_valid_o, r_addr_o, r_ptr_binary_r_o, r_ptr_gray_r_o,
               r_count_o, r_underflow_o, r_overflow_o
    );
endinterface
`default_nettype wire

// File: rtl/bsg_async_fifo_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bsg_async_fifo_read_ctrl
// Description : Read-side pointer/status controller of an asynchronous FIFO.
//               Registers the synchronized write gray pointer as binary,
//               keeps the read pointer in binary and gray form, and decodes
//               valid, occupancy, read address and sticky error flags.
// Ports       : r_clk_i   - read clock
//               r_reset_i - synchronous active-high reset
//               bus       - bsg_async_fifo_read_ctrl_if.master (see interface)
// Revision    : 1.0 - initial release
// ============================================================================
module bsg_async_fifo_read_ctrl #(
    parameter int lg_size_p = 6
) (
    input  wire logic                         r_clk_i,
    input  wire logic                         r_reset_i,
    bsg_async_fifo_read_ctrl_if.master        bus
);

    // Depth = 2^(lg_size_p-1): MSB set, all other bits clear.
    localparam logic [lg_size_p-1:0] c_DEPTH = {1'b1, {(lg_size_p-1){1'b0}}};

    logic [lg_size_p-1:0] r_w_bin_q,   w_w_bin_d;
    logic [lg_size_p-1:0] r_ptr_bin_q, w_ptr_bin_d;
    logic [lg_size_p-1:0] r_ptr_gray_q, w_ptr_gray_d;
    logic                 r_underflow_q, w_underflow_d;
    logic                 r_overflow_q,  w_overflow_d;

    logic [lg_size_p-1:0] w_count;
    logic                 w_valid;
    logic                 w_pop;
    logic                 w_over;
    logic [lg_size_p-1:0] w_ptr_inc;

    // ------------------------------------------------------------------
    // Gray -> binary of the incoming write pointer (prefix XOR from MSB).
    // ------------------------------------------------------------------
    always_comb begin
        w_w_bin_d = bus.r_w_ptr_gray_i;
        for (int i = lg_size_p - 2; i >= 0; i--) begin
            w_w_bin_d[i] = w_w_bin_d[i+1] ^ bus.r_w_ptr_gray_i[i];
        end
    end

    // ------------------------------------------------------------------
    // Status decode, from registers only.
    // ------------------------------------------------------------------
    assign w_count = r_w_bin_q - r_ptr_bin_q;
    assign w_valid = (r_w_bin_q != r_ptr_bin_q);
    assign w_over  = (w_count > c_DEPTH);
    assign w_pop   = bus.r_yumi_i & w_valid;

    // ------------------------------------------------------------------
    // Next-state logic. The gray pointer is computed from the incremented
    // binary value and registered alongside it, so the gray output only
    // ever changes one bit per edge and never glitches.
    // ------------------------------------------------------------------
    assign w_ptr_inc = r_ptr_bin_q + 1'b1;

    always_comb begin
        w_ptr_bin_d   = r_ptr_bin_q;
        w_ptr_gray_d  = r_ptr_gray_q;
        w_underflow_d = r_underflow_q | (bus.r_yumi_i & ~w_valid);
        w_overflow_d  = r_overflow_q | w_over;
        if (w_pop) begin
            w_ptr_bin_d  = w_ptr_inc;
            w_ptr_gray_d = w_ptr_inc ^ (w_ptr_inc >> 1);
        end
    end

    always_ff @(posedge r_clk_i) begin
        if (r_reset_i) begin
            r_w_bin_q     <= '0;
            r_ptr_bin_q   <= '0;
            r_ptr_gray_q  <= '0;
            r_underflow_q <= 1'b0;
            r_overflow_q  <= 1'b0;
        end else begin
            r_w_bin_q     <= w_w_bin_d;
            r_ptr_bin_q   <= w_ptr_bin_d;
            r_ptr_gray_q  <= w_ptr_gray_d;
            r_underflow_q <= w_underflow_d;
            r_overflow_q  <= w_overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Overflow also reflects the live register-based decode so
    // an illegal pointer is flagged in the same cycle the count shows it;
    // underflow stays purely registered to keep r_yumi_i off every output.
    // ------------------------------------------------------------------
    assign bus.r_valid_o        = w_valid;
    assign bus.r_count_o        = w_count;
    assign bus.r_addr_o         = r_ptr_bin_q[lg_size_p-2:0];
    assign bus.r_ptr_binary_r_o = r_ptr_bin_q;
    assign bus.r_ptr_gray_r_o   = r_ptr_gray_q;
    assign bus.r_underflow_o    = r_underflow_q;
    assign bus.r_overflow_o     = r_overflow_q | w_over;

endmodule
`default_nettype wire
